// File: rtl/speech_frame_sched.sv
// Frame scheduler: reads the byte-wide speech RAM as overlapping frames of
// 16-bit little-endian samples and streams them to the front-end core.
module speech_frame_sched #(
  parameter int ADDR_W      = 16,
  parameter int BASE_ADDR   = 0,
  parameter int FRAME_LEN   = 80,
  parameter int FRAME_SHIFT = 40,
  parameter int MAX_FRAMES  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       num_samples,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [7:0]        ram_datain,
  output logic [15:0]       sample,
  output logic              sample_valid,
  output logic              frame_start,
  output logic              frame_end,
  input  logic              fe_done,
  output logic [7:0]        frame_idx,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_LO, S_RD_HI, S_DRAIN, S_WAIT_FE, S_FIN
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] num_q;
  logic [16:0] fb_q;
  logic [15:0] i_q;
  logic [7:0]  frame_idx_q;
  logic        overflow_q;
  logic        pad_q, pend_q, first_q, last_q;
  logic [7:0]  lo_q;
  logic [15:0] sample_q;
  logic        sample_valid_q, frame_start_q, frame_end_q;

  logic [17:0]       n;
  logic [17:0]       fb_next;
  logic              rd_ok;
  logic              last_i;
  logic              end_ok, end_cap, adv_frame;
  logic [ADDR_W-1:0] addr_lo;

  assign n       = {1'b0, fb_q} + {2'b00, i_q};
  assign fb_next = {1'b0, fb_q} + 18'(FRAME_SHIFT);
  assign rd_ok   = n < {2'b00, num_q};
  assign last_i  = (i_q == 16'(FRAME_LEN - 1));
  assign addr_lo = ADDR_W'(BASE_ADDR) + ADDR_W'({n, 1'b0});

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    ram_rd    = 1'b0;
    ram_addr  = '0;
    end_ok    = 1'b0;
    end_cap   = 1'b0;
    adv_frame = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = (num_samples == 16'd0) ? S_FIN : S_RD_LO;
      end
      S_RD_LO: begin
        ram_rd   = rd_ok;
        ram_addr = rd_ok ? addr_lo : '0;
        state_d  = S_RD_HI;
      end
      S_RD_HI: begin
        ram_rd   = rd_ok;
        ram_addr = rd_ok ? addr_lo + ADDR_W'(1) : '0;
        state_d  = last_i ? S_DRAIN : S_RD_LO;
      end
      S_DRAIN: state_d = S_WAIT_FE;
      S_WAIT_FE: begin
        if (fe_done) begin
          if (fb_next >= {2'b00, num_q}) begin
            end_ok  = 1'b1;
            state_d = S_FIN;
          end else if (9'(frame_idx_q) + 9'd1 == 9'(MAX_FRAMES)) begin
            end_cap = 1'b1;
            state_d = S_FIN;
          end else begin
            adv_frame = 1'b1;
            state_d   = S_RD_LO;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // High byte of a sample arrives in the cycle after its RD_HI read, i.e.
  // during the next RD_LO or DRAIN; pend_q marks that a sample is in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      num_q          <= '0;
      fb_q           <= '0;
      i_q            <= '0;
      frame_idx_q    <= '0;
      overflow_q     <= 1'b0;
      pad_q          <= 1'b0;
      pend_q         <= 1'b0;
      first_q        <= 1'b0;
      last_q         <= 1'b0;
      lo_q           <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      frame_start_q  <= 1'b0;
      frame_end_q    <= 1'b0;
    end else begin
      sample_valid_q <= 1'b0;
      frame_start_q  <= 1'b0;
      frame_end_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            num_q       <= num_samples;
            fb_q        <= '0;
            i_q         <= '0;
            frame_idx_q <= '0;
            overflow_q  <= 1'b0;
            pend_q      <= 1'b0;
          end
        end
        S_RD_LO: begin
          if (pend_q) begin
            sample_q       <= {pad_q ? 8'h00 : ram_datain, lo_q};
            sample_valid_q <= 1'b1;
            frame_start_q  <= first_q;
            frame_end_q    <= last_q;
          end
          pend_q <= 1'b0;
          pad_q  <= !rd_ok;
        end
        S_RD_HI: begin
          lo_q    <= pad_q ? 8'h00 : ram_datain;
          pend_q  <= 1'b1;
          first_q <= (i_q == 16'd0);
          last_q  <= last_i;
          if (!last_i) i_q <= i_q + 16'd1;
        end
        S_DRAIN: begin
          sample_q       <= {pad_q ? 8'h00 : ram_datain, lo_q};
          sample_valid_q <= 1'b1;
          frame_start_q  <= first_q;
          frame_end_q    <= last_q;
          pend_q         <= 1'b0;
        end
        S_WAIT_FE: begin
          if (end_ok)  overflow_q <= 1'b0;
          if (end_cap) overflow_q <= 1'b1;
          if (adv_frame) begin
            fb_q        <= fb_next[16:0];
            i_q         <= '0;
            frame_idx_q <= frame_idx_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign frame_start  = frame_start_q;
  assign frame_end    = frame_end_q;
  assign frame_idx    = frame_idx_q;
  assign overflow     = overflow_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_FIN);

endmodule

// File: tb/tb_speech_frame_sched.sv
// Directed bench for speech_frame_sched: RAM returns addr[7:0], frame cap of 4.
module tb_speech_frame_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_samples = 16'd0;
  logic        fe_done = 1'b0;
  logic [15:0] ram_addr;
  logic        ram_rd;
  logic [7:0]  ram_datain = 8'h00;
  logic [15:0] sample;
  logic        sample_valid, frame_start, frame_end;
  logic [7:0]  frame_idx;
  logic        busy, done, overflow;

  always #5 clk = ~clk;

  speech_frame_sched #(.MAX_FRAMES(4)) dut (
    .clk(clk), .reset(reset), .start(start), .num_samples(num_samples),
    .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_datain(ram_datain),
    .sample(sample), .sample_valid(sample_valid), .frame_start(frame_start),
    .frame_end(frame_end), .fe_done(fe_done), .frame_idx(frame_idx),
    .busy(busy), .done(done), .overflow(overflow)
  );

  // Unread cycles return 0xAA so missing zero-padding shows up.
  always @(posedge clk) ram_datain <= ram_rd ? ram_addr[7:0] : 8'hAA;

  int          n_valid = 0, n_fs = 0, n_fe = 0, n_rd = 0, n_zero = 0, n_done = 0;
  logic [15:0] fs_sample = 16'd0;
  logic [7:0]  fs_idx = 8'd0;
  logic [7:0]  prev_idx = 8'd0;
  logic [15:0] base_addr = 16'd0;

  always @(negedge clk) begin
    if (sample_valid) begin
      n_valid <= n_valid + 1;
      if (sample == 16'd0) n_zero <= n_zero + 1;
    end
    if (frame_start) begin
      n_fs      <= n_fs + 1;
      fs_sample <= sample;
      fs_idx    <= frame_idx;
    end
    if (frame_end) n_fe <= n_fe + 1;
    if (ram_rd)    n_rd <= n_rd + 1;
    if (done)      n_done <= n_done + 1;
    prev_idx <= frame_idx;
    if (frame_idx != prev_idx) base_addr <= ram_addr;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Accepts start at the next edge; returns at the negedge of cycle 1.
  task automatic kick(input logic [15:0] n);
    start = 1'b1;
    num_samples = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_to_done(input int budget, inout int cyc);
    while (done !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  int b_valid, b_fs, b_fe, b_rd, b_zero, b_done;
  int cyc, bad;

  task automatic snap();
    b_valid = n_valid; b_fs = n_fs; b_fe = n_fe;
    b_rd = n_rd; b_zero = n_zero; b_done = n_done;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", {ram_addr, ram_rd, sample, sample_valid, frame_start,
                            frame_end, frame_idx, busy, done, overflow}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Two frames of 80 samples, second half-padded, fe_done tied high
    fe_done = 1'b1;
    snap();
    kick(16'd80);
    check("c1_rd_addr", {ram_rd, busy, ram_addr, frame_idx}, {1'b1, 1'b1, 16'd0, 8'd0});
    @(negedge clk);
    check("c2_hi_addr", {ram_rd, ram_addr}, {1'b1, 16'd1});
    @(negedge clk);
    check("c3_no_valid", {sample_valid, ram_addr}, {1'b0, 16'd2});
    @(negedge clk);
    check("c4_first_sample", {sample_valid, frame_start, sample}, {1'b1, 1'b1, 16'h0100});
    @(negedge clk);
    check("c5_gap", sample_valid, 1'b0);
    @(negedge clk);
    check("c6_second_sample", {sample_valid, frame_start, sample}, {1'b1, 1'b0, 16'h0302});
    cyc = 6;
    run_to_done(2000, cyc);
    check("t1_done_cycle", {done, 32'(cyc)}, {1'b1, 32'd325});
    @(negedge clk);
    check("t1_idle_after", {busy, done, overflow}, 3'b000);
    @(negedge clk);
    check("t1_counts", {16'(n_valid - b_valid), 8'(n_fs - b_fs), 8'(n_fe - b_fe), 16'(n_rd - b_rd)},
          {16'd160, 8'd2, 8'd2, 16'd240});
    check("t1_padding", {16'(n_zero - b_zero), 8'(n_done - b_done)}, {16'd40, 8'd1});
    check("t1_frame1_base", {base_addr, fs_sample, fs_idx}, {16'd80, 16'h5150, 8'd1});

    // fe_done held low after frame 0, with a stray pulse during streaming
    fe_done = 1'b0;
    kick(16'd80);
    cyc = 1;
    repeat (49) @(negedge clk);
    fe_done = 1'b1;
    @(negedge clk);
    fe_done = 1'b0;
    repeat (111) @(negedge clk);
    check("t2_last_sample", {frame_end, sample_valid, sample, frame_idx}, {1'b1, 1'b1, 16'h9F9E, 8'd0});
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (ram_rd !== 1'b0 || frame_idx !== 8'd0 || busy !== 1'b1) bad++;
    end
    check("t2_hold_quiet", 32'(bad), 32'd0);
    fe_done = 1'b1;
    @(negedge clk);
    check("t2_release", {ram_rd, ram_addr, frame_idx}, {1'b1, 16'd80, 8'd1});
    cyc = 263;
    run_to_done(2000, cyc);
    check("t2_done_cycle", {done, overflow, 32'(cyc)}, {1'b1, 1'b0, 32'd425});
    repeat (2) @(negedge clk);

    // Frame cap: 1000 samples, 4-frame limit
    snap();
    kick(16'd1000);
    cyc = 1;
    run_to_done(3000, cyc);
    check("t3_done_cycle", {done, overflow, 32'(cyc)}, {1'b1, 1'b1, 32'd649});
    repeat (2) @(negedge clk);
    check("t3_ovf_held", {busy, overflow}, 2'b01);
    check("t3_counts", {16'(n_valid - b_valid), 8'(n_fs - b_fs), 16'(n_rd - b_rd), 16'(n_zero - b_zero)},
          {16'd320, 8'd4, 16'd640, 16'd0});
    check("t3_last_frame", {fs_idx, fs_sample, base_addr}, {8'd3, 16'hF1F0, 16'd240});

    // Empty utterance; also clears overflow
    snap();
    kick(16'd0);
    check("t4_c1", {done, busy, overflow, ram_rd, sample_valid, frame_start},
          {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    check("t4_c2", {done, busy}, 2'b00);
    repeat (2) @(negedge clk);
    check("t4_no_activity", {16'(n_valid - b_valid), 16'(n_rd - b_rd), 16'(n_fs - b_fs)}, 48'd0);

    // Reset in the middle of frame 1, then clean restart
    kick(16'd80);
    repeat (199) @(negedge clk);
    check("t5_in_frame1", {busy, frame_idx}, {1'b1, 8'd1});
    reset = 1'b0;
    @(negedge clk);
    check("t5_reset_outputs", {ram_addr, ram_rd, sample, sample_valid, frame_start,
                               frame_end, frame_idx, busy, done, overflow}, 64'd0);
    reset = 1'b1;
    @(negedge clk);
    kick(16'd80);
    check("t5_restart", {ram_rd, ram_addr, frame_idx}, {1'b1, 16'd0, 8'd0});
    cyc = 1;
    run_to_done(2000, cyc);
    check("t5_done_cycle", {done, 32'(cyc)}, {1'b1, 32'd325});
    repeat (2) @(negedge clk);

    // start pulses while busy must not disturb the run
    snap();
    kick(16'd80);
    repeat (9) @(negedge clk);
    start = 1'b1;
    num_samples = 16'd1000;
    @(negedge clk);
    start = 1'b0;
    repeat (151) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 163;
    run_to_done(2000, cyc);
    check("t6_done_cycle", {done, overflow, 32'(cyc)}, {1'b1, 1'b0, 32'd325});
    repeat (2) @(negedge clk);
    check("t6_counts", {8'(n_fs - b_fs), 16'(n_rd - b_rd), 16'(n_valid - b_valid), base_addr},
          {8'd2, 16'd240, 16'd160, 16'd80});
    check("t6_idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
